// File: rtl/vga_pkg.sv
// Shared framebuffer definitions: pixel format, default widths and the
// return-tag / grant encodings used by the framebuffer arbiter.
package vga_pkg;

  localparam int unsigned PIX_W     = 6;
  localparam int unsigned FB_ADDR_W = 17;

  localparam int unsigned PIX_R_HI = 5;
  localparam int unsigned PIX_R_LO = 4;
  localparam int unsigned PIX_G_HI = 3;
  localparam int unsigned PIX_G_LO = 2;
  localparam int unsigned PIX_B_HI = 1;
  localparam int unsigned PIX_B_LO = 0;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_SCAN = 2'd1,
    TAG_RD   = 2'd2
  } tag_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_SCAN,
    GNT_WR,
    GNT_RD
  } grant_e;

  function automatic logic [PIX_W-1:0] pix_pack(input logic [1:0] r,
                                                input logic [1:0] g,
                                                input logic [1:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer arbiter bus: scanout fetch, host write/read port and the
// single-port RAM side. master = clients/RAM, slave = arbiter.
interface vga_fb_arbiter_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 6
);
  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_data;
  logic              scan_valid;

  logic              host_wr_valid;
  logic              host_wr_ready;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [DATA_W-1:0] host_wr_data;

  logic              host_rd_valid;
  logic              host_rd_ready;
  logic [ADDR_W-1:0] host_rd_addr;
  logic [DATA_W-1:0] host_rd_data;
  logic              host_rd_data_valid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              starve_err;

  modport slave (
    input  scan_req, scan_addr,
    output scan_data, scan_valid,
    input  host_wr_valid, host_wr_addr, host_wr_data,
    output host_wr_ready,
    input  host_rd_valid, host_rd_addr,
    output host_rd_ready, host_rd_data, host_rd_data_valid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output starve_err
  );

  modport master (
    output scan_req, scan_addr,
    input  scan_data, scan_valid,
    output host_wr_valid, host_wr_addr, host_wr_data,
    input  host_wr_ready,
    output host_rd_valid, host_rd_addr,
    input  host_rd_ready, host_rd_data, host_rd_data_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  starve_err
  );
endinterface

// File: rtl/vga_wr_fifo.sv
// Synchronous FIFO for buffered host writes. Pointers carry one extra wrap
// bit so full/empty are told apart by the MSB.
module vga_wr_fifo #(
  parameter int unsigned WIDTH = 23,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout > buffered host write > host read,
// with a return tag for 1-cycle RAM read latency and a sticky starvation flag.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W     = FB_ADDR_W,
  parameter int unsigned DATA_W     = PIX_W,
  parameter int unsigned WBUF_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 1024
) (
  input logic              clk,
  input logic              rst_n,
  vga_fb_arbiter_if.slave  bus
);
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  grant_e              grant;
  tag_e                tag, tag_nxt;
  logic                fifo_full, fifo_empty, push, pop;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [CW-1:0]       starve_cnt, starve_inc;
  logic                starve_err;

  assign bus.host_wr_ready = rst_n & ~fifo_full;
  assign push = bus.host_wr_valid & bus.host_wr_ready;
  assign pop  = (grant == GNT_WR);

  vga_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({bus.host_wr_addr, bus.host_wr_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Reads wait for an empty FIFO, so they always observe earlier writes.
  always_comb begin
    grant   = GNT_NONE;
    tag_nxt = TAG_NONE;
    if (!rst_n) begin
      grant = GNT_NONE;
    end else if (bus.scan_req) begin
      grant   = GNT_SCAN;
      tag_nxt = TAG_SCAN;
    end else if (!fifo_empty) begin
      grant = GNT_WR;
    end else if (bus.host_rd_valid) begin
      grant   = GNT_RD;
      tag_nxt = TAG_RD;
    end
  end

  always_comb begin
    bus.mem_en        = (grant != GNT_NONE);
    bus.mem_we        = (grant == GNT_WR);
    bus.host_rd_ready = (grant == GNT_RD);
    bus.mem_wdata     = head[DATA_W-1:0];
    bus.mem_addr      = bus.scan_addr;
    if (grant == GNT_WR)      bus.mem_addr = head[ADDR_W+DATA_W-1:DATA_W];
    else if (grant == GNT_RD) bus.mem_addr = bus.host_rd_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag <= TAG_NONE;
    else        tag <= tag_nxt;
  end

  assign bus.scan_valid         = (tag == TAG_SCAN);
  assign bus.host_rd_data_valid = (tag == TAG_RD);
  assign bus.scan_data          = bus.mem_rdata;
  assign bus.host_rd_data       = bus.mem_rdata;

  assign starve_inc = starve_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      starve_err <= 1'b0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (bus.scan_req && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_inc;
      if (starve_inc == STARVE_LIM) starve_err <= 1'b1;
    end
  end

  assign bus.starve_err = starve_err;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vga_fb_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .WBUF_DEPTH (4),
    .STARVE_MAX (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] ram [0:(1<<AW)-1];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[5:0] ^ a[11:6] ^ 6'h15;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic clear_inputs;
    bus.scan_req      = 1'b0;
    bus.scan_addr     = '0;
    bus.host_wr_valid = 1'b0;
    bus.host_wr_addr  = '0;
    bus.host_wr_data  = '0;
    bus.host_rd_valid = 1'b0;
    bus.host_rd_addr  = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    @(posedge clk); #1;
    bus.host_rd_valid = 1'b1;
    bus.host_rd_addr  = 17'h00010;
    @(negedge clk);
    checks++;
    if (bus.host_rd_ready !== 1'b1 || bus.mem_addr !== 17'h00010) begin
      errors++;
      $display("FAIL rd_grant: ready=%b addr=%h required ready=1 addr=00010", bus.host_rd_ready, bus.mem_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_en !== 1'b0 || bus.host_wr_ready !== 1'b0 || bus.host_rd_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL in_reset_outputs: en=%b we=%b wr_rdy=%b rd_rdy=%b required all 0",
               bus.mem_en, bus.mem_we, bus.host_wr_ready, bus.host_rd_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.host_rd_data_valid !== 1'b0 || bus.scan_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_read: rd_dv=%b scan_v=%b en=%b required 0 0 0",
               bus.host_rd_data_valid, bus.scan_valid, bus.mem_en);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.host_rd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.host_rd_data_valid !== 1'b0 || bus.host_wr_ready !== 1'b1 || bus.starve_err !== 1'b0 ||
        bus.scan_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: rd_dv=%b wr_rdy=%b starve=%b scan_v=%b en=%b required 0 1 0 0 0",
               bus.host_rd_data_valid, bus.host_wr_ready, bus.starve_err, bus.scan_valid, bus.mem_en);
    end
  endtask

  task automatic test_priority;
    do_reset();
    @(posedge clk); #1;
    bus.scan_req = 1'b1; bus.scan_addr = 17'h00005;
    bus.host_wr_valid = 1'b1; bus.host_wr_addr = 17'h00200; bus.host_wr_data = 6'h15;
    bus.host_rd_valid = 1'b1; bus.host_rd_addr = 17'h00030;
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 17'h00005 || bus.host_rd_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_scan: en=%b we=%b addr=%h rd_rdy=%b required 1 0 00005 0",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.host_rd_ready);
    end
    @(posedge clk); #1;
    bus.host_wr_valid = 1'b0;
    bus.scan_addr = 17'h00006;
    @(negedge clk);
    checks++;
    if (bus.scan_valid !== 1'b1 || bus.scan_data !== pat(17'h00005) || bus.mem_we !== 1'b0 ||
        bus.host_rd_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_scan_return: v=%b data=%h we=%b rd_rdy=%b required 1 %h 0 0",
               bus.scan_valid, bus.scan_data, bus.mem_we, bus.host_rd_ready, pat(17'h00005));
    end
    @(posedge clk); #1;
    bus.scan_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 17'h00200 || bus.mem_wdata !== 6'h15 ||
        bus.host_rd_ready !== 1'b0 || bus.scan_valid !== 1'b1 || bus.scan_data !== pat(17'h00006)) begin
      errors++;
      $display("FAIL prio_drain: we=%b addr=%h wd=%h rd_rdy=%b sv=%b sd=%h required 1 00200 15 0 1 %h",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.host_rd_ready, bus.scan_valid, bus.scan_data,
               pat(17'h00006));
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.host_rd_ready !== 1'b1 || bus.mem_addr !== 17'h00030 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL prio_read_last: rd_rdy=%b addr=%h we=%b required 1 00030 0",
               bus.host_rd_ready, bus.mem_addr, bus.mem_we);
    end
    @(posedge clk); #1;
    bus.host_rd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.host_rd_data_valid !== 1'b1 || bus.host_rd_data !== pat(17'h00030) || bus.scan_valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_read_return: dv=%b data=%h sv=%b required 1 %h 0",
               bus.host_rd_data_valid, bus.host_rd_data, bus.scan_valid, pat(17'h00030));
    end
  endtask

  task automatic test_raw;
    do_reset();
    @(posedge clk); #1;
    bus.host_wr_valid = 1'b1; bus.host_wr_addr = 17'h00100; bus.host_wr_data = 6'h2A;
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b0 || bus.host_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_no_bypass: en=%b wr_rdy=%b required 0 1", bus.mem_en, bus.host_wr_ready);
    end
    @(posedge clk); #1;
    bus.host_wr_valid = 1'b0;
    bus.host_rd_valid = 1'b1; bus.host_rd_addr = 17'h00100;
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 17'h00100 || bus.mem_wdata !== 6'h2A || bus.host_rd_ready !== 1'b0) begin
      errors++;
      $display("FAIL raw_write_first: we=%b addr=%h wd=%h rd_rdy=%b required 1 00100 2a 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.host_rd_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.host_rd_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 17'h00100) begin
      errors++;
      $display("FAIL raw_read_grant: rd_rdy=%b we=%b addr=%h required 1 0 00100",
               bus.host_rd_ready, bus.mem_we, bus.mem_addr);
    end
    @(posedge clk); #1;
    bus.host_rd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.host_rd_data_valid !== 1'b1 || bus.host_rd_data !== 6'h2A) begin
      errors++;
      $display("FAIL raw_read_data: dv=%b data=%h required 1 2a", bus.host_rd_data_valid, bus.host_rd_data);
    end
  endtask

  task automatic test_fifo_full;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.scan_req = 1'b1; bus.scan_addr = 17'h00040;
      bus.host_wr_valid = 1'b1;
      bus.host_wr_addr  = 17'h00300 + 17'(i);
      bus.host_wr_data  = 6'h10 + 6'(i);
      @(negedge clk);
      checks++;
      if (bus.host_wr_ready !== 1'b1 || bus.mem_we !== 1'b0) begin
        errors++;
        $display("FAIL full_push%0d: wr_rdy=%b we=%b required 1 0", i, bus.host_wr_ready, bus.mem_we);
      end
    end
    @(posedge clk); #1;
    bus.host_wr_addr = 17'h003FF; bus.host_wr_data = 6'h3F;
    @(negedge clk);
    checks++;
    if (bus.host_wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_low: wr_rdy=%b required 0", bus.host_wr_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.scan_req = 1'b0;
      if (i == 1) bus.host_wr_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== 17'h00300 + 17'(i) || bus.mem_wdata !== 6'h10 + 6'(i) ||
          bus.host_wr_ready !== (i != 0)) begin
        errors++;
        $display("FAIL full_drain%0d: we=%b addr=%h wd=%h wr_rdy=%b required 1 %h %h %b",
                 i, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.host_wr_ready,
                 17'h00300 + 17'(i), 6'h10 + 6'(i), (i != 0));
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b0 || bus.host_wr_ready !== 1'b1 || bus.starve_err !== 1'b0) begin
      errors++;
      $display("FAIL full_after_drain: en=%b wr_rdy=%b starve=%b required 0 1 0",
               bus.mem_en, bus.host_wr_ready, bus.starve_err);
    end
  endtask

  task automatic test_starvation;
    do_reset();
    @(posedge clk); #1;
    bus.scan_req = 1'b1; bus.scan_addr = 17'h00050;
    bus.host_wr_valid = 1'b1; bus.host_wr_addr = 17'h00400; bus.host_wr_data = 6'h07;
    @(posedge clk); #1;
    bus.host_wr_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.starve_err !== (i >= 9) || bus.mem_we !== 1'b0) begin
        errors++;
        $display("FAIL starve_cycle%0d: err=%b we=%b required %b 0", i, bus.starve_err, bus.mem_we, (i >= 9));
      end
      @(posedge clk); #1;
    end
    bus.scan_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 17'h00400 || bus.mem_wdata !== 6'h07) begin
      errors++;
      $display("FAIL starve_drain: we=%b addr=%h wd=%h required 1 00400 07", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.starve_err !== 1'b1 || bus.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL starve_sticky: err=%b en=%b required 1 0", bus.starve_err, bus.mem_en);
    end
  endtask

  task automatic test_back_to_back;
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i <= 640; i++) begin
      @(posedge clk); #1;
      bus.scan_req  = (i < 640);
      bus.scan_addr = 17'h01000 + 17'(i);
      @(negedge clk);
      if (bus.scan_valid === 1'b1) pulses++;
      if (i > 0) begin
        checks++;
        if (bus.scan_valid !== 1'b1 || bus.scan_data !== pat(17'h01000 + 17'(i - 1)) ||
            bus.host_rd_data_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_pixel%0d: v=%b data=%h rd_dv=%b required 1 %h 0",
                   i - 1, bus.scan_valid, bus.scan_data, bus.host_rd_data_valid, pat(17'h01000 + 17'(i - 1)));
        end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.scan_valid !== 1'b0 || pulses != 640) begin
      errors++;
      $display("FAIL b2b_count: trailing_v=%b pulses=%0d required 0 640", bus.scan_valid, pulses);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = pat(AW'(i));
    bus.mem_rdata = '0;
    clear_inputs();
    test_reset();
    test_priority();
    test_raw();
    test_fifo_full();
    test_back_to_back();
    test_starvation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Arbitrates one single-port framebuffer RAM between the VGA scanout path and a host port. The scanout path is the pixel fetch side of the h/v timing counter that drives R/G/B (2 bits each). The host port is a write/read port used by a CPU or pattern generator. Scanout always wins; host writes are buffered in a small FIFO and drained in free cycles. Sits between the timing counter and the RAM; the RAM has 1-cycle read latency.

Parameters:
ADDR_W, 17, framebuffer word address width (320x240 = 76800 words)
DATA_W, 6, pixel width, packed {R[1:0],G[1:0],B[1:0]}
WBUF_DEPTH, 4, host write FIFO depth (power of 2, >=2)
STARVE_MAX, 1024, consecutive denied cycles with the FIFO non-empty before starve_err sets

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
scan_req  in  1  scanout needs pixel at scan_addr this cycle
scan_addr  in  ADDR_W  scanout pixel address
scan_data  out  DATA_W  pixel returned to scanout
scan_valid  out  1  scan_data valid (1 cycle after the granted scan_req)
host_wr_valid  in  1  host write request
host_wr_ready  out  1  write accepted into FIFO when valid&ready
host_wr_addr  in  ADDR_W  host write address
host_wr_data  in  DATA_W  host write pixel
host_rd_valid  in  1  host read request
host_rd_ready  out  1  read granted to RAM this cycle
host_rd_addr  in  ADDR_W  host read address
host_rd_data  out  DATA_W  host read result
host_rd_data_valid  out  1  host_rd_data valid (1 cycle after grant)
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read
starve_err  out  1  sticky: host writes starved STARVE_MAX cycles

Behaviour:
- Reset (rst_n low, async): FIFO emptied; return tag = NONE; starve counter = 0; starve_err = 0. While rst_n is low, mem_en, mem_we, scan_valid, host_rd_data_valid, host_rd_ready and host_wr_ready are all 0. An outstanding read return is dropped and produces no valid.
- Per-cycle grant, fixed priority, decided combinationally from the current inputs and FIFO state:
  1. SCAN if scan_req: mem_en=1, mem_we=0, mem_addr=scan_addr.
  2. else WR if FIFO non-empty: pop head; mem_en=1, mem_we=1, addr/data come from head.
  3. else RD if host_rd_valid: host_rd_ready=1; mem_en=1, mem_we=0, mem_addr=host_rd_addr.
  4. else NONE: mem_en=0.
- Outside a grant, mem_we=0 and mem_addr/mem_wdata are don't-care.
- Ordering rule: a host read is granted only when the FIFO is empty, so a read always sees every earlier accepted write (read-after-write coherence).
- Return tag register holds SCAN, RD or NONE and is loaded every cycle from the grant.
  - Next cycle, tag=SCAN gives scan_valid=1 and scan_data=mem_rdata.
  - Next cycle, tag=RD gives host_rd_data_valid=1 and host_rd_data=mem_rdata.
  - Both valids are registered decodes of the tag; the data outputs pass mem_rdata through.
- Write FIFO:
  - host_wr_ready = !full (and rst_n).
  - Push on host_wr_valid & host_wr_ready. Pop on WR grant.
  - Simultaneous push and pop when not full: occupancy unchanged.
  - When full, ready=0 even if a pop occurs that cycle (no bypass).
  - No push-to-RAM bypass: the earliest RAM write is the cycle after acceptance.
  - Pointers are log2(WBUF_DEPTH)+1 bits and wrap modulo 2*WBUF_DEPTH. full/empty are decided from the MSB.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and scan_req=1, and clears on any WR grant or when the FIFO is empty.
  - It saturates at STARVE_MAX; on reaching it, starve_err sets.
  - starve_err clears only on reset. Scan priority is never overridden.
- Host read with host_rd_valid held while denied: the request stays pending; the host holds addr stable until host_rd_ready.

Decomposition:
- Shared package vga_pkg: PIX_W=6, FB_ADDR_W=17, pixel bit-field positions, tag encoding (TAG_NONE=0, TAG_SCAN=1, TAG_RD=2).
- One sub-module: vga_wr_fifo (parameterised sync FIFO, push/pop/full/empty, async active-low reset).
- Arbitration, tag register and starve counter stay in vga_fb_arbiter.

Test Plan:
- Reset mid-read: grant RD at addr 0x00010, assert rst_n=0 before the next edge -> host_rd_data_valid never pulses; mem_en=0 and host_wr_ready=0 while in reset.
- Priority: scan_req=1 at 0x00005, FIFO holding 1 write, host_rd_valid=1 -> RAM sees a read of 0x00005, scan_valid=1 next cycle, host_rd_ready=0; the write drains on the first cycle with scan_req=0.
- RAW ordering: write 0x2A to 0x00100, then immediately read 0x00100 with scan_req=0 -> the write is issued first, the read is granted the cycle after, host_rd_data=0x2A.
- FIFO full: scan_req=1 constant, push 4 writes -> host_wr_ready=0 after the 4th; drop scan_req -> 4 RAM writes on consecutive cycles in push order, then ready=1.
- Starvation: STARVE_MAX=8, 1 write queued, scan_req=1 for 10 cycles -> starve_err=1 after the 8th denied cycle and stays 1 after the write drains.
- Back-to-back scanout: scan_req=1 for 640 cycles at incrementing addresses -> 640 scan_valid pulses, each 1 cycle after its request, with data matching the RAM model.
